// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and helpers for the sequential divider.
//               - div_state_t : divider FSM state encoding
//               - DIV_LATENCY : accept-to-result latency at the default width
//               - abs_val     : two's-complement magnitude of a sign-extended
//                               operand (caller sizes the result)
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 16;
  // Full-latency divide: WIDTH iteration edges, one edge to leave CALC, one
  // edge through FIXUP.
  localparam int DIV_LATENCY       = DIV_DEFAULT_WIDTH + 2;

  // Wide enough for any WIDTH up to 64 plus the sign-extension bit.
  localparam int DIV_ABS_W         = 65;

  // Only the low bits matter to callers: negation of a sign-extended value
  // modulo 2^(WIDTH+1) yields the exact magnitude, including |-2^(WIDTH-1)|.
  function automatic logic [DIV_ABS_W-1:0] abs_val(input logic [DIV_ABS_W-1:0] v,
                                                   input logic                 neg);
    return neg ? (~v + DIV_ABS_W'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration. Shifts the partial
//               remainder left, brings in the next dividend bit, and
//               trial-subtracts the divisor. Keeps the difference when it is
//               non-negative (quotient bit 1), otherwise restores (bit 0).
// Ports       : rem_in   [WIDTH:0] partial remainder before the step
//               dvd_msb            next dividend bit (MSB-first)
//               divisor  [WIDTH:0] divisor magnitude
//               rem_out  [WIDTH:0] partial remainder after the step
//               q_bit              resolved quotient bit
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           dvd_msb,
  input  logic [WIDTH:0] divisor,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_unused_rem_msb;

  // The incoming remainder is always below the divisor (<= 2^WIDTH), so its
  // top bit is zero and the shifted value still fits in WIDTH+1 bits.
  assign w_unused_rem_msb = rem_in[WIDTH];
  assign w_shift          = {rem_in[WIDTH-1:0], dvd_msb};

  // One extra bit on the subtraction exposes the borrow.
  assign w_diff  = {1'b0, w_shift} - {1'b0, divisor};
  assign q_bit   = ~w_diff[WIDTH+1];
  assign rem_out = q_bit ? w_diff[WIDTH:0] : w_shift;

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle radix-2 restoring integer divider with runtime
//               signed/unsigned mode and valid/ready handshakes. One quotient
//               bit per clock; results registered in FIXUP and held in DONE.
// Ports       : clk, rst                    clock, async active-high reset
//               in_valid / in_ready         operand handshake
//               is_signed                   1 = two's-complement operands
//               numerator, denominator      operands [WIDTH-1:0]
//               out_valid / out_ready       result handshake
//               quotient, remainder         results  [WIDTH-1:0]
//               div_by_zero, overflow       result flags (valid with out_valid)
// Build macro : SEQ_DIVIDER_ZERO_BYPASS_EN - when defined, a zero denominator
//               skips iteration and produces its result one edge after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;

  logic [WIDTH:0]   r_rem;    // partial remainder
  logic [WIDTH-1:0] r_qd;     // dividend shifts out the top, quotient fills the bottom
  logic [WIDTH:0]   r_dvs;    // divisor magnitude
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_num_neg;
  logic             w_den_neg;
  logic             w_den_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_num_mag;
  logic [WIDTH:0]   w_den_mag;
  logic [WIDTH:0]   w_step_rem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_iter_done;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // ---------------------------------------------------------------------------
  // Operand decode (only meaningful on the accept edge)
  // ---------------------------------------------------------------------------
  assign w_num_neg  = is_signed & numerator[WIDTH-1];
  assign w_den_neg  = is_signed & denominator[WIDTH-1];
  assign w_den_zero = (denominator == '0);
  assign w_ovf      = is_signed
                      && (numerator == {1'b1, {(WIDTH-1){1'b0}}})
                      && (denominator == '1);

  // The {neg, operand} concatenation is the WIDTH+1-bit sign extension in
  // signed mode and a zero extension in unsigned mode. The numerator
  // magnitude never exceeds 2^(WIDTH-1) when signed, so WIDTH bits suffice.
  assign w_num_mag = WIDTH'(abs_val(DIV_ABS_W'({w_num_neg, numerator}), w_num_neg));
  assign w_den_mag = (WIDTH+1)'(abs_val(DIV_ABS_W'({w_den_neg, denominator}), w_den_neg));

  // ---------------------------------------------------------------------------
  // Iteration cell
  // ---------------------------------------------------------------------------
  div_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .dvd_msb (r_qd[WIDTH-1]),
    .divisor (r_dvs),
    .rem_out (w_step_rem),
    .q_bit   (w_step_q)
  );

  assign w_iter_done = (r_cnt == CNT_W'(WIDTH));
  assign w_q_fix     = r_neg_q ? (~r_qd + WIDTH'(1)) : r_qd;
  assign w_r_fix     = r_neg_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
        if (in_valid) w_state_nxt = w_den_zero ? DONE : CALC;
`else
        if (in_valid) w_state_nxt = CALC;
`endif
      end
      // The counter reaches WIDTH on the last iteration edge; the state
      // leaves CALC on the following edge.
      CALC:    if (w_iter_done) w_state_nxt = FIXUP;
      FIXUP:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_qd        <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_qd    <= w_num_mag;
            r_dvs   <= w_den_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_num_neg ^ w_den_neg;
            r_neg_r <= w_num_neg;
            r_dbz   <= w_den_zero;
            r_ovf   <= w_ovf;
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
            if (w_den_zero) begin
              quotient    <= '1;
              remainder   <= numerator;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          if (!w_iter_done) begin
            r_rem <= w_step_rem;
            r_qd  <= {r_qd[WIDTH-2:0], w_step_q};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FIXUP: begin
          quotient    <= w_q_fix;
          remainder   <= w_r_fix;
          div_by_zero <= r_dbz;
          overflow    <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
